// File: rtl/div_unit_if.sv
// div_unit_if: execute-stage divider request/response bundle.
// The pipeline side drives start/divsel/flush/operands (master),
// the divider drives busy/done/result (slave).
interface div_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      divsel;
    logic            flush;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, divsel, flush, op_a, op_b,
        input  busy, done, result
    );

    modport slave (
        input  start, divsel, flush, op_a, op_b,
        output busy, done, result
    );
endinterface

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One operation in flight; XLEN CALC iterations, one FIX cycle, one DONE
// cycle. The result register only changes in FIX and is held afterwards.
// Optional build macro DIV_FAST_SPECIAL_EN: divide-by-zero and signed
// overflow bypass CALC and go straight to FIX (2-cycle latency).
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          rst,
    div_unit_if.slave     bus
);
    localparam int CNT_W = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [CNT_W-1:0]  r_cnt;
    logic [XLEN-1:0]   r_quo;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_divisor;
    logic [XLEN-1:0]   r_op_a;
    logic              r_signed;
    logic              r_rem_op;
    logic              r_qsign;
    logic              r_rsign;
    logic              r_div_zero;
    logic              r_ovf;
    logic [XLEN-1:0]   r_result;

    logic              w_valid_sel;
    logic              w_sel_signed;
    logic              w_sel_rem;
    logic              w_accept;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic              w_div_zero_in;
    logic              w_ovf_in;
    logic [XLEN:0]     w_shift;
    logic [XLEN:0]     w_trial;
    logic [XLEN-1:0]   w_quo_fix;
    logic [XLEN-1:0]   w_rem_fix;
    logic [XLEN-1:0]   w_fix_result;
`ifdef DIV_FAST_SPECIAL_EN
    logic              w_special_in;
`endif

    // Decode divsel into valid/signed/remainder flags.
    always_comb begin
        w_valid_sel  = 1'b0;
        w_sel_signed = 1'b0;
        w_sel_rem    = 1'b0;
        case (bus.divsel)
            3'b001: begin w_valid_sel = 1'b1; w_sel_signed = 1'b1; w_sel_rem = 1'b0; end
            3'b010: begin w_valid_sel = 1'b1; w_sel_signed = 1'b0; w_sel_rem = 1'b0; end
            3'b011: begin w_valid_sel = 1'b1; w_sel_signed = 1'b1; w_sel_rem = 1'b1; end
            3'b100: begin w_valid_sel = 1'b1; w_sel_signed = 1'b0; w_sel_rem = 1'b1; end
            default: begin w_valid_sel = 1'b0; w_sel_signed = 1'b0; w_sel_rem = 1'b0; end
        endcase
    end

    // A start is taken only in IDLE, with a valid code, no flush and no reset
    // (reset wins, so the stall request is withheld while rst is high).
    assign w_accept = (r_state == S_IDLE) && bus.start && w_valid_sel
                      && !bus.flush && !rst;

    // Operand magnitudes and special-case detection on the raw operands.
    always_comb begin
        if (w_sel_signed && bus.op_a[XLEN-1]) begin
            w_a_mag = ZERO - bus.op_a;
        end else begin
            w_a_mag = bus.op_a;
        end
        if (w_sel_signed && bus.op_b[XLEN-1]) begin
            w_b_mag = ZERO - bus.op_b;
        end else begin
            w_b_mag = bus.op_b;
        end
        w_div_zero_in = (bus.op_b == ZERO);
        w_ovf_in      = w_sel_signed && (bus.op_a == MIN_NEG) && (bus.op_b == ALL_ONES);
    end

`ifdef DIV_FAST_SPECIAL_EN
    assign w_special_in = w_div_zero_in || w_ovf_in;
`endif

    // One restoring step: shift {rem,quo} left and trial-subtract the divisor.
    always_comb begin
        w_shift = {r_rem, r_quo[XLEN-1]};
        w_trial = w_shift - {1'b0, r_divisor};
    end

    // Final sign correction followed by the RISC-V special-case overrides.
    always_comb begin
        if (r_signed && r_qsign) begin
            w_quo_fix = ZERO - r_quo;
        end else begin
            w_quo_fix = r_quo;
        end
        if (r_signed && r_rsign) begin
            w_rem_fix = ZERO - r_rem;
        end else begin
            w_rem_fix = r_rem;
        end
        if (r_div_zero) begin
            w_fix_result = r_rem_op ? r_op_a : ALL_ONES;
        end else if (r_ovf) begin
            w_fix_result = r_rem_op ? ZERO : MIN_NEG;
        end else begin
            w_fix_result = r_rem_op ? w_rem_fix : w_quo_fix;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
`ifdef DIV_FAST_SPECIAL_EN
                    if (w_special_in) begin
                        w_next = S_FIX;
                    end else begin
                        w_next = S_CALC;
                    end
`else
                    w_next = S_CALC;
`endif
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_CALC: begin
                if (bus.flush) begin
                    w_next = S_IDLE;
                end else if (r_cnt == CNT_W'(1)) begin
                    w_next = S_FIX;
                end else begin
                    w_next = S_CALC;
                end
            end
            S_FIX: begin
                if (bus.flush) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: operand capture at start, iteration in CALC, result write in FIX.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= {CNT_W{1'b0}};
            r_quo      <= ZERO;
            r_rem      <= ZERO;
            r_divisor  <= ZERO;
            r_op_a     <= ZERO;
            r_signed   <= 1'b0;
            r_rem_op   <= 1'b0;
            r_qsign    <= 1'b0;
            r_rsign    <= 1'b0;
            r_div_zero <= 1'b0;
            r_ovf      <= 1'b0;
            r_result   <= ZERO;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt      <= CNT_W'(XLEN);
                        r_quo      <= w_a_mag;
                        r_rem      <= ZERO;
                        r_divisor  <= w_b_mag;
                        r_op_a     <= bus.op_a;
                        r_signed   <= w_sel_signed;
                        r_rem_op   <= w_sel_rem;
                        r_qsign    <= bus.op_a[XLEN-1] ^ bus.op_b[XLEN-1];
                        r_rsign    <= bus.op_a[XLEN-1];
                        r_div_zero <= w_div_zero_in;
                        r_ovf      <= w_ovf_in;
                    end
                end
                S_CALC: begin
                    if (!bus.flush) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (!w_trial[XLEN]) begin
                            r_rem <= w_trial[XLEN-1:0];
                            r_quo <= {r_quo[XLEN-2:0], 1'b1};
                        end else begin
                            r_rem <= w_shift[XLEN-1:0];
                            r_quo <= {r_quo[XLEN-2:0], 1'b0};
                        end
                    end
                end
                S_FIX: begin
                    if (!bus.flush) begin
                        r_result <= w_fix_result;
                    end
                end
                S_DONE: begin
                    r_result <= r_result;
                end
                default: begin
                    r_result <= r_result;
                end
            endcase
        end
    end

    assign bus.busy   = w_accept || (r_state == S_CALC) || (r_state == S_FIX);
    assign bus.done   = (r_state == S_DONE);
    assign bus.result = r_result;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: randomized + directed self-checking bench for div_unit.
// Expected values come from plain integer arithmetic plus the RISC-V
// divide-by-zero / overflow rules.
module tb_div_unit;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [31:0] last_result;

    always #5 clk = ~clk;

    div_unit_if #(.XLEN(XLEN)) bus ();

    div_unit #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        int q;
        sa = a;
        sb = b;
        ref_model = 32'h0;
        case (sel)
            3'b001: begin
                if (b == 32'h0) ref_model = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_model = 32'h8000_0000;
                else begin q = sa / sb; ref_model = q; end
            end
            3'b010: ref_model = (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
            3'b011: begin
                if (b == 32'h0) ref_model = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_model = 32'h0;
                else begin q = sa % sb; ref_model = q; end
            end
            3'b100: ref_model = (b == 32'h0) ? a : a % b;
            default: ref_model = 32'h0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
        logic special;
        special = (b == 32'h0) ||
                  ((sel == 3'b001 || sel == 3'b011) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef DIV_FAST_SPECIAL_EN
        ref_latency = special ? 2 : 34;
`else
        ref_latency = special ? 34 : 34;
`endif
    endfunction

    // Issue one operation, wait for done (bounded), check latency/result.
    // Returns on the DONE-cycle negedge so the next call starts back-to-back.
    task automatic run_op(input string name, input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
        int lat;
        logic [31:0] exp;
        exp = ref_model(sel, a, b);
        @(negedge clk);
        bus.start = 1'b1; bus.divsel = sel; bus.op_a = a; bus.op_b = b;
        #1;
        check_eq({name, " busy@start"}, 64'(bus.busy), 64'(1'b1));
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.op_a = $urandom; bus.op_b = $urandom;
        lat = 1;
        while (!bus.done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check_eq({name, " latency"}, 64'(lat), 64'(ref_latency(sel, a, b)));
        check_eq({name, " result"}, 64'(bus.result), 64'(exp));
        check_eq({name, " busy@done"}, 64'(bus.busy), 64'(1'b0));
        last_result = exp;
    endtask

    initial begin
        int lat;
        logic [2:0] sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0] sels [4];
        sels[0] = 3'b001; sels[1] = 3'b010; sels[2] = 3'b011; sels[3] = 3'b100;

        bus.start = 1'b0; bus.divsel = 3'b000; bus.flush = 1'b0;
        bus.op_a = 32'h0; bus.op_b = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset busy", 64'(bus.busy), 64'(1'b0));
        check_eq("reset done", 64'(bus.done), 64'(1'b0));
        check_eq("reset result", 64'(bus.result), 64'(32'h0));
        rst = 1'b0;

        // Directed cases.
        run_op("divu 100/7", 3'b010, 32'd100, 32'd7);
        run_op("remu 100/7", 3'b100, 32'd100, 32'd7);
        run_op("div -7/2", 3'b001, 32'hFFFF_FFF9, 32'd2);
        run_op("rem -7/2", 3'b011, 32'hFFFF_FFF9, 32'd2);
        run_op("rem 7/-2", 3'b011, 32'd7, 32'hFFFF_FFFE);
        run_op("div 5/0", 3'b001, 32'd5, 32'd0);
        run_op("rem -5/0", 3'b011, 32'hFFFF_FFFB, 32'd0);
        run_op("divu 5/0", 3'b010, 32'd5, 32'd0);
        run_op("div ovf", 3'b001, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("rem ovf", 3'b011, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu big/-1", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF);

        // Done is a single-cycle pulse and the result is held afterwards.
        @(negedge clk);
        check_eq("done pulse", 64'(bus.done), 64'(1'b0));
        check_eq("result held", 64'(bus.result), 64'(last_result));

        // Invalid divsel never starts an operation.
        bus.start = 1'b1; bus.divsel = 3'b111; bus.op_a = 32'd9; bus.op_b = 32'd3;
        #1;
        check_eq("bad sel busy", 64'(bus.busy), 64'(1'b0));
        repeat (3) @(negedge clk);
        bus.start = 1'b0;
        check_eq("bad sel idle", 64'({bus.busy, bus.done}), 64'(2'b00));
        check_eq("bad sel result", 64'(bus.result), 64'(last_result));

        // Flush in CALC at cycle 10: no done, result unchanged.
        @(negedge clk);
        bus.start = 1'b1; bus.divsel = 3'b001; bus.op_a = 32'd1000; bus.op_b = 32'd10;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        while (lat < 10) begin
            @(negedge clk);
            lat++;
        end
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check_eq("flush busy", 64'(bus.busy), 64'(1'b0));
        check_eq("flush done", 64'(bus.done), 64'(1'b0));
        check_eq("flush result", 64'(bus.result), 64'(last_result));
        repeat (30) begin
            @(negedge clk);
            if (bus.done) check_eq("flush stray done", 64'(bus.done), 64'(1'b0));
        end
        run_op("divu 9/3", 3'b010, 32'd9, 32'd3);

        // Reset mid-CALC with start held high.
        @(negedge clk);
        bus.start = 1'b1; bus.divsel = 3'b010; bus.op_a = 32'd1000; bus.op_b = 32'd7;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst busy", 64'(bus.busy), 64'(1'b0));
        check_eq("rst done", 64'(bus.done), 64'(1'b0));
        check_eq("rst result", 64'(bus.result), 64'(32'h0));
        rst = 1'b0; bus.start = 1'b0;
        run_op("divu 6/3", 3'b010, 32'd6, 32'd3);

        // Randomized operations with biased operand classes.
        for (int i = 0; i < 150; i++) begin
            sel = sels[$urandom_range(0, 3)];
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: b = 32'($urandom_range(1, 15));
                2: b = 32'hFFFF_FFFF;
                3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                4: a = 32'($urandom_range(0, 100));
                5: b = {1'b1, b[30:0]};
                default: b = b;
            endcase
            run_op($sformatf("rnd%0d sel%0d %h/%h", i, sel, a, b), sel, a, b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 divider for the RV32M DIV/DIVU/REM/REMU instructions in the execute stage.
- Consumes the decoder's div_inst/divsel outputs and register operands; produces a 32-bit result plus a busy signal the hazard logic uses to freeze the pipeline.
- One operation in flight; the result is held until the next operation starts.

Parameters:
- XLEN, 32, operand/result width; the iteration count equals XLEN.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- start  in  1  div_inst qualified by a valid EX-stage instruction; sampled only in IDLE
- divsel  in  3  001 div, 010 divu, 011 rem, 100 remu; other codes ignored (no start)
- flush  in  1  kills any in-flight operation
- op_a  in  XLEN  dividend (rs1)
- op_b  in  XLEN  divisor (rs2)
- busy  out  1  pipeline stall request
- done  out  1  one-cycle result-valid pulse
- result  out  XLEN  quotient or remainder, held after done

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; busy=0, done=0, result=0; all internal registers cleared. Reset wins over start/flush in the same cycle. Reset mid-operation aborts it with no done.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - If start=1 and divsel is valid: latch signed flag (div/rem), rem flag (rem/remu), |op_a|, |op_b| (magnitudes only when signed), quotient sign = a[31]^b[31] and remainder sign = a[31]. Load counter=XLEN, partial remainder=0. Go to CALC.
  - busy is combinationally 1 in the start cycle.
- CALC:
  - Each cycle: shift {rem,quo} left by 1; trial = rem - divisor as an (XLEN+1)-bit subtract. If non-negative, rem=trial and quo[0]=1; else quo[0]=0.
  - Counter decrements; at 1 → FIX. Exactly XLEN cycles.
- FIX (1 cycle): select quo or rem. Apply two's-complement negation per the latched sign when signed. Then apply RISC-V special cases, which override:
  - divisor=0: quotient=all ones (0xFFFFFFFF for div and divu); remainder=op_a unmodified.
  - signed overflow (a=0x80000000, b=0xFFFFFFFF): quotient=0x80000000, remainder=0.
  - Write result; go to DONE.
- DONE (1 cycle): done=1, busy=0. Next cycle → IDLE.
- Back-to-back operation: a start in the cycle after DONE (i.e. in IDLE) is accepted.
- busy = (IDLE & start & valid divsel) | CALC | FIX.
- Default latency is XLEN+2 cycles from the start edge to done (34 for XLEN=32).
- flush:
  - In CALC/FIX: return to IDLE next cycle, no done, result keeps its previous value.
  - In IDLE with start: start is ignored.
  - In DONE: no effect (done still pulses).
- result changes only in FIX. start outside IDLE is ignored.
- Special-case detection uses the original operands, latched at start.

Optional Feature:
- DIV_FAST_SPECIAL_EN
- Defined: at start, if divisor=0 or signed overflow, skip CALC and go directly to FIX. Total latency is 2 cycles (done in the second cycle after start); busy is high in the start and FIX cycles only.
- Undefined: special cases run the full XLEN CALC iterations. The FIX override still guarantees correct results, with latency identical to normal operations.

Test Plan:
- divu 100 / 7 → done exactly 34 cycles after start, result=14; remu same operands → 2.
- div -7 (0xFFFFFFF9) / 2 → 0xFFFFFFFD (-3); rem same → 0xFFFFFFFF (-1); rem 7 / -2 → 1.
- div 5 / 0 → 0xFFFFFFFF; rem -5 / 0 → 0xFFFFFFFB. Latency is 34 without the macro, 2 with DIV_FAST_SPECIAL_EN.
- div 0x80000000 / 0xFFFFFFFF → 0x80000000; rem same → 0. Check the same latency rule as the divide-by-zero case.
- start div 1000/10, flush at cycle 10 → busy drops the next cycle, no done, result unchanged. Immediately start divu 9/3 → result 3, done after 34 cycles.
- rst asserted mid-CALC with start held high → busy=0, done=0, result=0 the next cycle. After rst deasserts, a new start (divu 6/3) completes normally with result 2.
